// File: rtl/lvdc_pio_initiator_if.sv
// Parallel request side and LVDA-facing lines of the LVDC PIO initiator.
// LVDC_PIO_PARITY_EN adds the PERR status line.
interface lvdc_pio_initiator_if #(
    parameter int WORD_BITS = 26
);
    logic                 BIT_STB;
    logic                 REQ;
    logic                 RD;
    logic [8:0]           ADDR;
    logic [WORD_BITS-1:0] WDATA;
    logic                 DATAV;
    logic                 HALTV;
    logic                 BUSY;
    logic                 DONE;
    logic [WORD_BITS-1:0] RDATA;
    logic                 A1V, A2V, A3V, A4V, A5V, A6V, A7V, A8V, A9V;
    logic                 PIOV;
    logic                 TRSV;
    logic                 PIODO;
`ifdef LVDC_PIO_PARITY_EN
    logic                 PERR;
`endif

    // Initiator view.
    modport master (
        input  BIT_STB, REQ, RD, ADDR, WDATA, DATAV, HALTV,
        output BUSY, DONE, RDATA, A1V, A2V, A3V, A4V, A5V, A6V, A7V, A8V, A9V,
               PIOV, TRSV, PIODO
`ifdef LVDC_PIO_PARITY_EN
        , output PERR
`endif
    );

    // Sequencer/LVDA view.
    modport slave (
        output BIT_STB, REQ, RD, ADDR, WDATA, DATAV, HALTV,
        input  BUSY, DONE, RDATA, A1V, A2V, A3V, A4V, A5V, A6V, A7V, A8V, A9V,
               PIOV, TRSV, PIODO
`ifdef LVDC_PIO_PARITY_EN
        , input PERR
`endif
    );
endinterface

// File: rtl/lvdc_pio_initiator.sv
// LVDC-side PIO initiator: address/PIOV setup, MSB-first serial word transfer, hold, DONE.
// Define LVDC_PIO_PARITY_EN to append an odd-parity bit to every word and expose PERR.
module lvdc_pio_initiator #(
    parameter int WORD_BITS = 26,
    parameter int SETUP_BT  = 2,
    parameter int HOLD_BT   = 1
) (
    input logic                  SIM_CLK,
    input logic                  SIM_RST,
    lvdc_pio_initiator_if.master bus
);
`ifdef LVDC_PIO_PARITY_EN
    localparam int XFER_BT = WORD_BITS + 1;
`else
    localparam int XFER_BT = WORD_BITS;
`endif
    localparam int CNT_W = $clog2(XFER_BT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_END} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_BITS-1:0] sr_q, sr_d;
    logic [WORD_BITS-1:0] rdata_q, rdata_d;
    logic [8:0]           addr_q, addr_d;
    logic                 rd_q, rd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 piov_q, piov_d;
    logic                 trsv_q, trsv_d;
    logic                 piodo_q, piodo_d;
`ifdef LVDC_PIO_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_pend_q, perr_pend_d;
    logic                 perr_q, perr_d;
`endif
    logic                 bt_en;

    // A strobe seen while the LVDA is halting is simply not a bit time.
    assign bt_en = bus.BIT_STB & ~bus.HALTV;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        piov_d  = piov_q;
        trsv_d  = trsv_q;
        piodo_d = piodo_q;
`ifdef LVDC_PIO_PARITY_EN
        par_d       = par_q;
        perr_pend_d = perr_pend_q;
        perr_d      = perr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.REQ) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    sr_d    = bus.WDATA;
                    rd_d    = bus.RD;
                    addr_d  = bus.ADDR;
                    busy_d  = 1'b1;
                    piov_d  = 1'b1;
`ifdef LVDC_PIO_PARITY_EN
                    par_d       = ~^bus.WDATA;
                    perr_pend_d = 1'b0;
                    perr_d      = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                if (bt_en) begin
                    if (cnt_q == CNT_W'(SETUP_BT - 1)) begin
                        state_d = S_XFER;
                        cnt_d   = '0;
                        trsv_d  = 1'b1;
                        // Writes present the MSB as the window opens.
                        if (!rd_q) begin
                            piodo_d = sr_q[WORD_BITS-1];
                            sr_d    = sr_q << 1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_XFER: begin
                if (bt_en) begin
                    if (rd_q) begin
                        if (cnt_q < CNT_W'(WORD_BITS))
                            sr_d = {sr_q[WORD_BITS-2:0], bus.DATAV};
                    end else begin
                        piodo_d = sr_q[WORD_BITS-1];
                        sr_d    = sr_q << 1;
`ifdef LVDC_PIO_PARITY_EN
                        if (cnt_q == CNT_W'(WORD_BITS - 1))
                            piodo_d = par_q;
`endif
                    end
                    if (cnt_q == CNT_W'(XFER_BT - 1)) begin
                        state_d = S_END;
                        cnt_d   = '0;
                        trsv_d  = 1'b0;
                        piov_d  = 1'b0;
                        piodo_d = 1'b0;
                        if (rd_q) begin
`ifdef LVDC_PIO_PARITY_EN
                            rdata_d     = sr_q;
                            perr_pend_d = ~(^sr_q ^ bus.DATAV);
`else
                            rdata_d = {sr_q[WORD_BITS-2:0], bus.DATAV};
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_END: begin
                if (bt_en) begin
                    if (cnt_q == CNT_W'(HOLD_BT - 1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        addr_d  = '0;
`ifdef LVDC_PIO_PARITY_EN
                        perr_d = perr_pend_q;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // NOTE: state is only ever updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            piov_q  <= 1'b0;
            trsv_q  <= 1'b0;
            piodo_q <= 1'b0;
`ifdef LVDC_PIO_PARITY_EN
            par_q       <= 1'b0;
            perr_pend_q <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            piov_q  <= piov_d;
            trsv_q  <= trsv_d;
            piodo_q <= piodo_d;
`ifdef LVDC_PIO_PARITY_EN
            par_q       <= par_d;
            perr_pend_q <= perr_pend_d;
            perr_q      <= perr_d;
`endif
        end
    end

    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
    assign bus.RDATA = rdata_q;
    assign bus.PIOV  = piov_q;
    assign bus.TRSV  = trsv_q;
    assign bus.PIODO = piodo_q;
    assign bus.A1V   = addr_q[0];
    assign bus.A2V   = addr_q[1];
    assign bus.A3V   = addr_q[2];
    assign bus.A4V   = addr_q[3];
    assign bus.A5V   = addr_q[4];
    assign bus.A6V   = addr_q[5];
    assign bus.A7V   = addr_q[6];
    assign bus.A8V   = addr_q[7];
    assign bus.A9V   = addr_q[8];
`ifdef LVDC_PIO_PARITY_EN
    assign bus.PERR  = perr_q;
`endif
endmodule
